// File: rtl/bomb_slot_ctrl.sv
// rtl/bomb_slot_ctrl.sv - per-player bomb slots: placement, fuse countdown, blast window
// Optional chain detonation between nearby bombs is enabled by defining BOMB_CHAIN_EN.
module bomb_slot_ctrl #(
  parameter int N_SLOTS     = 3,
  parameter int COORD_W     = 6,
  parameter int FUSE_TICKS  = 3000,
  parameter int BLAST_TICKS = 1000,
  parameter int CHAIN_RANGE = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       tick,
  input  logic                       place,
  input  logic [COORD_W-1:0]         pos_x,
  input  logic [COORD_W-1:0]         pos_y,
  output logic [N_SLOTS*COORD_W-1:0] bomb_x,
  output logic [N_SLOTS*COORD_W-1:0] bomb_y,
  output logic [N_SLOTS-1:0]         armed,
  output logic [N_SLOTS-1:0]         crack,
  output logic                       full,
  output logic                       place_ack,
  output logic                       place_rej
);

  localparam int MAX_T = (FUSE_TICKS > BLAST_TICKS) ? FUSE_TICKS : BLAST_TICKS;
  localparam int CNT_W = $clog2(MAX_T + 1);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_BLAST} slot_state_t;

  slot_state_t        state_q [N_SLOTS];
  slot_state_t        state_d [N_SLOTS];
  logic [CNT_W-1:0]   cnt_q   [N_SLOTS];
  logic [CNT_W-1:0]   cnt_d   [N_SLOTS];
  logic [COORD_W-1:0] x_q     [N_SLOTS];
  logic [COORD_W-1:0] x_d     [N_SLOTS];
  logic [COORD_W-1:0] y_q     [N_SLOTS];
  logic [COORD_W-1:0] y_d     [N_SLOTS];
  logic [N_SLOTS-1:0] chained;
  logic               ack_d;
  logic               rej_d;
  logic               busy_all_d;
  logic               free_found;
  logic               clash;
  int                 free_idx;

`ifdef BOMB_CHAIN_EN
  // fresh_q marks slots that entered BLAST on the most recent tick; it seeds the next chain hop.
  logic [N_SLOTS-1:0] fresh_q;
  logic [N_SLOTS-1:0] fresh_d;

  function automatic logic within_range(logic [COORD_W-1:0] a, logic [COORD_W-1:0] b);
    logic [COORD_W-1:0] d;
    d = (a >= b) ? (a - b) : (b - a);
    return 32'(d) <= CHAIN_RANGE;
  endfunction

  always_comb begin
    for (int i = 0; i < N_SLOTS; i++) begin
      chained[i] = 1'b0;
      for (int j = 0; j < N_SLOTS; j++) begin
        if (fresh_q[j] && ((x_q[i] == x_q[j] && within_range(y_q[i], y_q[j])) ||
                           (y_q[i] == y_q[j] && within_range(x_q[i], x_q[j]))))
          chained[i] = 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_SLOTS; i++)
      fresh_d[i] = tick ? (state_q[i] == S_ARMED && state_d[i] == S_BLAST) : fresh_q[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fresh_q <= '0;
    else     fresh_q <= fresh_d;
  end
`else
  assign chained = '0;
`endif

  always_comb begin
    ack_d      = 1'b0;
    rej_d      = 1'b0;
    clash      = 1'b0;
    free_found = 1'b0;
    free_idx   = 0;
    busy_all_d = 1'b1;
    for (int i = 0; i < N_SLOTS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      x_d[i]     = x_q[i];
      y_d[i]     = y_q[i];
    end

    // Eligibility is judged on pre-edge state, so a slot freeing this edge is still busy.
    for (int i = 0; i < N_SLOTS; i++)
      if (state_q[i] != S_IDLE && x_q[i] == pos_x && y_q[i] == pos_y) clash = 1'b1;
    for (int i = N_SLOTS - 1; i >= 0; i--)
      if (state_q[i] == S_IDLE) begin
        free_found = 1'b1;
        free_idx   = i;
      end

    if (tick) begin
      for (int i = 0; i < N_SLOTS; i++) begin
        case (state_q[i])
          S_ARMED: begin
            if (cnt_q[i] == CNT_W'(1) || chained[i]) begin
              state_d[i] = S_BLAST;
              cnt_d[i]   = CNT_W'(BLAST_TICKS);
            end else begin
              cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
          end
          S_BLAST: begin
            if (cnt_q[i] == CNT_W'(1)) begin
              state_d[i] = S_IDLE;
              cnt_d[i]   = '0;
              x_d[i]     = '0;
              y_d[i]     = '0;
            end else begin
              cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
          end
          default: ;
        endcase
      end
    end

    if (place) begin
      if (free_found && !clash) begin
        state_d[free_idx] = S_ARMED;
        cnt_d[free_idx]   = CNT_W'(FUSE_TICKS);
        x_d[free_idx]     = pos_x;
        y_d[free_idx]     = pos_y;
        ack_d             = 1'b1;
      end else begin
        rej_d = 1'b1;
      end
    end

    for (int i = 0; i < N_SLOTS; i++)
      if (state_d[i] == S_IDLE) busy_all_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_SLOTS; i++) begin
        state_q[i] <= S_IDLE;
        cnt_q[i]   <= '0;
        x_q[i]     <= '0;
        y_q[i]     <= '0;
      end
      armed     <= '0;
      crack     <= '0;
      full      <= 1'b0;
      place_ack <= 1'b0;
      place_rej <= 1'b0;
    end else begin
      for (int i = 0; i < N_SLOTS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        x_q[i]     <= x_d[i];
        y_q[i]     <= y_d[i];
        armed[i]   <= (state_d[i] == S_ARMED);
        crack[i]   <= (state_d[i] == S_BLAST);
      end
      full      <= busy_all_d;
      place_ack <= ack_d;
      place_rej <= rej_d;
    end
  end

  for (genvar g = 0; g < N_SLOTS; g++) begin : g_pack
    assign bomb_x[g*COORD_W +: COORD_W] = x_q[g];
    assign bomb_y[g*COORD_W +: COORD_W] = y_q[g];
  end

endmodule
